// File: rtl/reg_scoreboard.sv
// GPR pending-write scoreboard: per-register in-flight counters, RAW/saturation issue stall,
// busy mask and total outstanding count. Define SB_WB_BYPASS_EN to let a same-cycle final writeback release the stall.
module reg_scoreboard #(
    parameter int NREG  = 32,
    parameter int CNT_W = 2,
    parameter int TOT_W = 6
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             issue_valid,
    input  logic             issue_wen,
    input  logic [4:0]       issue_waddr,
    input  logic [4:0]       issue_raddr1,
    input  logic [4:0]       issue_raddr2,
    output logic             issue_stall,
    input  logic             wb_valid,
    input  logic [4:0]       wb_waddr,
    input  logic             flush,
    output logic [NREG-1:0]  busy_mask,
    output logic [TOT_W-1:0] outstanding,
    output logic             sb_err
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic [CNT_W-1:0] cnt [NREG];

    logic raw1, raw2, sat;
    logic mask1, mask2, maskw;
    logic accept, inc_req, dec_req, same_reg;
    logic inc_eff, dec_eff, wb_underflow;

`ifdef SB_WB_BYPASS_EN
    // A writeback that drains the last pending write frees that register in the same cycle.
    logic wb_free;
    assign wb_free = wb_valid && (wb_waddr != 5'd0) && (cnt[wb_waddr] == CNT_W'(1));
    assign mask1   = wb_free && (wb_waddr == issue_raddr1);
    assign mask2   = wb_free && (wb_waddr == issue_raddr2);
    assign maskw   = wb_free && (wb_waddr == issue_waddr);
`else
    assign mask1 = 1'b0;
    assign mask2 = 1'b0;
    assign maskw = 1'b0;
`endif

    assign raw1 = (issue_raddr1 != 5'd0) && (cnt[issue_raddr1] != '0) && !mask1;
    assign raw2 = (issue_raddr2 != 5'd0) && (cnt[issue_raddr2] != '0) && !mask2;
    assign sat  = issue_wen && (issue_waddr != 5'd0) && (cnt[issue_waddr] == CNT_MAX) && !maskw;

    assign issue_stall = issue_valid && (raw1 || raw2 || sat);
    assign accept      = issue_valid && !issue_stall;

    assign inc_req  = accept && issue_wen && (issue_waddr != 5'd0);
    assign dec_req  = wb_valid && (wb_waddr != 5'd0);
    assign same_reg = (issue_waddr == wb_waddr);

    // Accept and retire on one register cancel out, even when its counter is zero.
    assign inc_eff      = inc_req && !(dec_req && same_reg);
    assign dec_eff      = dec_req && !(inc_req && same_reg) && (cnt[wb_waddr] != '0);
    assign wb_underflow = dec_req && !(inc_req && same_reg) && (cnt[wb_waddr] == '0);

    always_comb begin
        // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
        busy_mask = '0;
        for (int i = 1; i < NREG; i++) begin
            busy_mask[i] = (cnt[i] != '0);
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            // NOTE: the counter array is control state, not data storage, so every entry is reset.
            for (int i = 0; i < NREG; i++) begin
                cnt[i] <= '0;
            end
            outstanding <= '0;
            sb_err      <= 1'b0;
        end else if (flush) begin
            for (int i = 0; i < NREG; i++) begin
                cnt[i] <= '0;
            end
            outstanding <= '0;
        end else begin
            if (inc_eff) begin
                cnt[issue_waddr] <= cnt[issue_waddr] + CNT_W'(1);
            end
            if (dec_eff) begin
                cnt[wb_waddr] <= cnt[wb_waddr] - CNT_W'(1);
            end
            if (wb_underflow) begin
                sb_err <= 1'b1;
            end
            outstanding <= outstanding + TOT_W'(inc_eff) - TOT_W'(dec_eff);
        end
    end

endmodule

// File: tb/tb_reg_scoreboard.sv
// Scoreboard bench for reg_scoreboard: a reference model pushes expected stall/state per driven cycle,
// monitors pop and compare; directed tasks add inline checks for the listed scenarios.
module tb_reg_scoreboard;

    localparam int NREG  = 32;
    localparam int CNT_W = 2;
    localparam int TOT_W = 6;
    localparam int CMAX  = (1 << CNT_W) - 1;

    logic             clk;
    logic             resetn;
    logic             issue_valid;
    logic             issue_wen;
    logic [4:0]       issue_waddr;
    logic [4:0]       issue_raddr1;
    logic [4:0]       issue_raddr2;
    logic             issue_stall;
    logic             wb_valid;
    logic [4:0]       wb_waddr;
    logic             flush;
    logic [NREG-1:0]  busy_mask;
    logic [TOT_W-1:0] outstanding;
    logic             sb_err;

    reg_scoreboard #(.NREG(NREG), .CNT_W(CNT_W), .TOT_W(TOT_W)) dut (
        .clk          (clk),
        .resetn       (resetn),
        .issue_valid  (issue_valid),
        .issue_wen    (issue_wen),
        .issue_waddr  (issue_waddr),
        .issue_raddr1 (issue_raddr1),
        .issue_raddr2 (issue_raddr2),
        .issue_stall  (issue_stall),
        .wb_valid     (wb_valid),
        .wb_waddr     (wb_waddr),
        .flush        (flush),
        .busy_mask    (busy_mask),
        .outstanding  (outstanding),
        .sb_err       (sb_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [NREG-1:0]  busy;
        logic [TOT_W-1:0] outs;
        logic             err;
    } state_t;

    int     tests_run;
    int     tests_failed;
    int     m_cnt [NREG];
    bit     m_err;
    logic   stall_q [$];
    state_t st_q [$];

`ifdef SB_WB_BYPASS_EN
    localparam logic BYPASS = 1'b1;
`else
    localparam logic BYPASS = 1'b0;
`endif

    function automatic logic model_stall();
        bit wfree;
        wfree = BYPASS && wb_valid && (wb_waddr != 0) && (m_cnt[wb_waddr] == 1);
        if (!issue_valid) return 1'b0;
        if (issue_raddr1 != 0 && m_cnt[issue_raddr1] != 0 && !(wfree && wb_waddr == issue_raddr1)) return 1'b1;
        if (issue_raddr2 != 0 && m_cnt[issue_raddr2] != 0 && !(wfree && wb_waddr == issue_raddr2)) return 1'b1;
        if (issue_wen && issue_waddr != 0 && m_cnt[issue_waddr] == CMAX && !(wfree && wb_waddr == issue_waddr)) return 1'b1;
        return 1'b0;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < NREG; i++) m_cnt[i] = 0;
        m_err = 1'b0;
    endtask

    // Drive one cycle: apply inputs, queue the model's expectations, advance past the edge.
    task automatic drive(input logic v, input logic wen, input logic [4:0] wa, input logic [4:0] r1,
                         input logic [4:0] r2, input logic wbv, input logic [4:0] wba, input logic fl);
        logic   s;
        bit     inc, dec;
        int     sum;
        state_t e;
        issue_valid = v;  issue_wen = wen;  issue_waddr = wa;
        issue_raddr1 = r1; issue_raddr2 = r2;
        wb_valid = wbv;   wb_waddr = wba;   flush = fl;
        s = model_stall();
        stall_q.push_back(s);
        if (fl) begin
            for (int i = 0; i < NREG; i++) m_cnt[i] = 0;
        end else begin
            inc = v && !s && wen && (wa != 0);
            dec = wbv && (wba != 0);
            if (!(inc && dec && wa == wba)) begin
                if (inc) m_cnt[wa]++;
                if (dec) begin
                    if (m_cnt[wba] > 0) m_cnt[wba]--;
                    else m_err = 1'b1;
                end
            end
        end
        e.busy = '0;
        sum = 0;
        for (int i = 1; i < NREG; i++) begin
            e.busy[i] = (m_cnt[i] != 0);
            sum += m_cnt[i];
        end
        e.outs = TOT_W'(sum);
        e.err  = m_err;
        st_q.push_back(e);
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        drive(1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0);
    endtask

    always @(negedge clk) begin
        logic es;
        if (stall_q.size() > 0) begin
            es = stall_q.pop_front();
            tests_run++;
            if (issue_stall !== es) begin
                tests_failed++;
                $display("FAIL sb_stall @%0t: got %b expected %b", $time, issue_stall, es);
            end
        end
    end

    always @(posedge clk) begin
        state_t es;
        #1;
        if (st_q.size() > 0) begin
            es = st_q.pop_front();
            tests_run++;
            if (busy_mask !== es.busy || outstanding !== es.outs || sb_err !== es.err) begin
                tests_failed++;
                $display("FAIL sb_state @%0t: got busy=%h outs=%0d err=%b expected busy=%h outs=%0d err=%b",
                         $time, busy_mask, outstanding, sb_err, es.busy, es.outs, es.err);
            end
        end
    end

    task automatic test_reset();
        issue_valid = 1'b1; issue_raddr1 = 5'd5;
        #1;
        tests_run++;
        if (busy_mask !== '0 || outstanding !== '0 || sb_err !== 1'b0 || issue_stall !== 1'b0) begin
            tests_failed++;
            $display("FAIL reset_state: got busy=%h outs=%0d err=%b stall=%b expected all zero",
                     busy_mask, outstanding, sb_err, issue_stall);
        end
        drive(1'b1, 1'b0, 5'd0, 5'd5, 5'd0, 1'b0, 5'd0, 1'b0);
    endtask

    task automatic test_raw();
        drive(1'b1, 1'b1, 5'd5, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0);
        tests_run++;
        if (busy_mask[5] !== 1'b1 || outstanding !== 6'd1) begin
            tests_failed++;
            $display("FAIL raw_pending: got busy5=%b outs=%0d expected 1 1", busy_mask[5], outstanding);
        end
        issue_valid = 1'b1; issue_wen = 1'b0; issue_raddr1 = 5'd5;
        #1;
        tests_run++;
        if (issue_stall !== 1'b1) begin
            tests_failed++;
            $display("FAIL raw_stall: got %b expected 1", issue_stall);
        end
        drive(1'b1, 1'b0, 5'd0, 5'd5, 5'd0, 1'b0, 5'd0, 1'b0);
        wb_valid = 1'b1; wb_waddr = 5'd5;
        #1;
        tests_run++;
        if (issue_stall !== !BYPASS) begin
            tests_failed++;
            $display("FAIL raw_wb_cycle: got %b expected %b", issue_stall, !BYPASS);
        end
        drive(1'b1, 1'b0, 5'd0, 5'd5, 5'd0, 1'b1, 5'd5, 1'b0);
        wb_valid = 1'b0;
        #1;
        tests_run++;
        if (issue_stall !== 1'b0 || outstanding !== 6'd0) begin
            tests_failed++;
            $display("FAIL raw_cleared: got stall=%b outs=%0d expected 0 0", issue_stall, outstanding);
        end
        drive(1'b1, 1'b0, 5'd0, 5'd5, 5'd0, 1'b0, 5'd0, 1'b0);
    endtask

    task automatic test_saturation();
        for (int k = 0; k < 3; k++) drive(1'b1, 1'b1, 5'd7, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0);
        issue_valid = 1'b1; issue_wen = 1'b1; issue_waddr = 5'd7;
        #1;
        tests_run++;
        if (issue_stall !== 1'b1 || outstanding !== 6'd3) begin
            tests_failed++;
            $display("FAIL sat_stall: got stall=%b outs=%0d expected 1 3", issue_stall, outstanding);
        end
        drive(1'b1, 1'b1, 5'd7, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0);
        drive(1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b1, 5'd7, 1'b0);
        drive(1'b1, 1'b1, 5'd7, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0);
        tests_run++;
        if (outstanding !== 6'd3 || busy_mask !== 32'h0000_0080) begin
            tests_failed++;
            $display("FAIL sat_refill: got outs=%0d busy=%h expected 3 00000080", outstanding, busy_mask);
        end
    endtask

    task automatic test_same_cycle();
        drive(1'b1, 1'b1, 5'd9, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0);
        drive(1'b1, 1'b1, 5'd9, 5'd0, 5'd0, 1'b1, 5'd9, 1'b0);
        tests_run++;
        if (outstanding !== 6'd4 || busy_mask[9] !== 1'b1) begin
            tests_failed++;
            $display("FAIL same_reg_net0: got outs=%0d busy9=%b expected 4 1", outstanding, busy_mask[9]);
        end
        drive(1'b1, 1'b1, 5'd10, 5'd0, 5'd0, 1'b1, 5'd10, 1'b0);
        tests_run++;
        if (sb_err !== 1'b0 || busy_mask[10] !== 1'b0 || outstanding !== 6'd4) begin
            tests_failed++;
            $display("FAIL same_reg_zero: got err=%b busy10=%b outs=%0d expected 0 0 4",
                     sb_err, busy_mask[10], outstanding);
        end
        drive(1'b1, 1'b1, 5'd11, 5'd0, 5'd0, 1'b1, 5'd9, 1'b0);
        drive(1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b1, 5'd11, 1'b0);
    endtask

    task automatic test_sb_err();
        drive(1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b1, 5'd12, 1'b0);
        idle();
        tests_run++;
        if (sb_err !== 1'b1) begin
            tests_failed++;
            $display("FAIL err_sticky: got %b expected 1", sb_err);
        end
        drive(1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b1, 5'd0, 1'b0);
        drive(1'b1, 1'b1, 5'd0, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0);
        tests_run++;
        if (outstanding !== 6'd3 || busy_mask[0] !== 1'b0) begin
            tests_failed++;
            $display("FAIL x0_ignored: got outs=%0d busy0=%b expected 3 0", outstanding, busy_mask[0]);
        end
    endtask

    task automatic test_flush();
        drive(1'b1, 1'b1, 5'd3,  5'd0, 5'd0, 1'b0, 5'd0, 1'b0);
        drive(1'b1, 1'b1, 5'd4,  5'd0, 5'd0, 1'b0, 5'd0, 1'b0);
        drive(1'b1, 1'b1, 5'd20, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0);
        issue_valid = 1'b1; issue_wen = 1'b1; issue_waddr = 5'd21; issue_raddr1 = 5'd3;
        wb_valid = 1'b1; wb_waddr = 5'd7; flush = 1'b1;
        #1;
        tests_run++;
        if (issue_stall !== 1'b1) begin
            tests_failed++;
            $display("FAIL flush_prestate_stall: got %b expected 1", issue_stall);
        end
        drive(1'b1, 1'b1, 5'd21, 5'd3, 5'd0, 1'b1, 5'd7, 1'b1);
        tests_run++;
        if (busy_mask !== '0 || outstanding !== '0 || sb_err !== 1'b1) begin
            tests_failed++;
            $display("FAIL flush_clear: got busy=%h outs=%0d err=%b expected 0 0 1",
                     busy_mask, outstanding, sb_err);
        end
        drive(1'b1, 1'b1, 5'd22, 5'd0, 5'd0, 1'b0, 5'd0, 1'b1);
        idle();
    endtask

    task automatic test_back_to_back();
        for (int k = 0; k < 300; k++) begin
            drive(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 5'($urandom_range(0, 7)),
                  5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)), 1'($urandom_range(0, 1)),
                  5'($urandom_range(0, 7)), 1'($urandom_range(0, 31) == 0));
        end
        idle();
    endtask

    task automatic test_async_reset();
        drive(1'b1, 1'b1, 5'd5, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0);
        drive(1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b1, 5'd13, 1'b0);
        issue_valid = 1'b1; issue_wen = 1'b0; issue_raddr1 = 5'd5; wb_valid = 1'b0;
        #2;
        resetn = 1'b0;
        model_reset();
        #1;
        tests_run++;
        if (busy_mask !== '0 || outstanding !== '0 || sb_err !== 1'b0 || issue_stall !== 1'b0) begin
            tests_failed++;
            $display("FAIL async_reset: got busy=%h outs=%0d err=%b stall=%b expected all zero",
                     busy_mask, outstanding, sb_err, issue_stall);
        end
        @(posedge clk);
        #1;
        resetn = 1'b1;
        #1;
        drive(1'b1, 1'b1, 5'd6, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0);
        idle();
    endtask

    initial begin
        tests_run = 0;
        tests_failed = 0;
        model_reset();
        resetn = 1'b0;
        issue_valid = 1'b0; issue_wen = 1'b0; issue_waddr = '0;
        issue_raddr1 = '0; issue_raddr2 = '0;
        wb_valid = 1'b0; wb_waddr = '0; flush = 1'b0;
        #12;
        resetn = 1'b1;
        @(posedge clk);
        #1;
        test_reset();
        test_raw();
        test_saturation();
        test_same_cycle();
        test_sb_err();
        test_flush();
        test_back_to_back();
        test_async_reset();
        repeat (2) @(posedge clk);
        #2;
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/reg_scoreboard.md
Name: reg_scoreboard

Overview:
- Tracks in-flight writes to the 32-entry, x0-hardwired GPR file for the multi-cycle/pipelined myCPU.
- Sits between decode/issue and writeback. Holds a per-register pending-write counter and stalls issue on RAW hazards or counter saturation.
- Also exposes a busy mask and a total-outstanding count, used by the debug trace and by the flush logic.

Parameters:
- NREG, 32, number of architectural registers; register 0 is never tracked.
- CNT_W, 2, width of each per-register pending counter; maximum outstanding writes per register is 2^CNT_W-1.
- TOT_W, 6, width of the total-outstanding counter.

Ports:
- clk  input  1  system clock; all state updates on posedge.
- resetn  input  1  asynchronous active-low reset.
- issue_valid  input  1  decode presents an instruction this cycle.
- issue_wen  input  1  instruction writes a GPR.
- issue_waddr  input  5  destination register.
- issue_raddr1  input  5  source register 1; 0 means unused.
- issue_raddr2  input  5  source register 2; 0 means unused.
- issue_stall  output  1  instruction must be held; not accepted this cycle.
- wb_valid  input  1  writeback retires a GPR write this cycle.
- wb_waddr  input  5  register being written back.
- flush  input  1  synchronous clear of all pending state (exception/branch kill).
- busy_mask  output  NREG  bit i = 1 when counter[i] != 0; bit 0 is always 0.
- outstanding  output  TOT_W  total pending writes across all registers.
- sb_err  output  1  sticky: writeback seen for a register with counter 0.

Behaviour:
- Reset (resetn low, asynchronous): all counters = 0, outstanding = 0, sb_err = 0. Therefore busy_mask = 0 and issue_stall = 0 (issue_stall is combinational from cleared state). Reset mid-operation discards all pending state immediately.
- issue_stall is combinational from registered counters and current issue inputs. It is asserted when issue_valid and any of:
  - issue_raddr1 != 0 and counter[raddr1] != 0
  - issue_raddr2 != 0 and counter[raddr2] != 0
  - issue_wen and issue_waddr != 0 and counter[waddr] == max
- issue_stall = 0 whenever issue_valid = 0.
- Accept condition: issue_valid & !issue_stall. On accept with issue_wen and waddr != 0, counter[waddr] increments at the next posedge. An accept with waddr = 0 or wen = 0 changes nothing.
- Retire: wb_valid with wb_waddr != 0 decrements counter[wb_waddr] at the next posedge.
  - If that counter is already 0: no change and sb_err sets. sb_err stays set until reset.
  - wb_waddr = 0 is ignored.
- Simultaneous accept and retire on the same register: net counter change 0, no error even if the counter was 0.
- Simultaneous accept and retire on different registers: both apply independently.
- outstanding = sum of all counters, maintained incrementally. Per cycle it changes by +1, -1, or 0 following the rules above.
- flush (synchronous, priority over issue/wb in that cycle): all counters and outstanding go to 0; sb_err is unchanged. issue_stall is evaluated against the pre-flush state in the flush cycle.
- Latency: an accepted write makes its destination hazardous from the cycle after issue. A retire clears the hazard from the cycle after wb (no same-cycle bypass unless the optional feature is enabled).
- No wrap-around: counters never exceed max because issue stalls at max. Counters never go below 0.

Optional Feature:
- Macro: SB_WB_BYPASS_EN.
- Defined: a same-cycle wb_valid to register r with counter[r] == 1 masks r from the RAW and saturation stall terms that cycle. This matches the register file's write-then-read timing when forwarding is present. The combinational path wb_waddr -> issue_stall exists only in this mode.
- Undefined: stall depends only on registered counters; no wb_* -> issue_stall path.

Test Plan:
- Reset then idle: busy_mask = 0, outstanding = 0, issue_stall = 0 with issue_valid = 1 and raddr1 = 5.
- Issue wen, waddr = 5; next cycle issue raddr1 = 5 -> issue_stall = 1, busy_mask[5] = 1, outstanding = 1. wb_waddr = 5 -> stall drops one cycle later, or the same cycle under SB_WB_BYPASS_EN.
- Three writes to r7 without retire -> 4th write to r7 stalls (CNT_W = 2). One wb to r7 -> 4th write accepted; counter[7] = 3.
- Same-cycle issue waddr = 9 and wb_waddr = 9 with counter[9] = 1 -> counter[9] stays 1, outstanding unchanged.
- wb_waddr = 12 with counter[12] = 0 -> sb_err = 1 and stays 1. wb_waddr = 0 or issue waddr = 0 -> no state change.
- Pending writes on r3, r4, r20, then flush -> busy_mask = 0, outstanding = 0 next cycle. resetn pulsed low mid-sequence -> outputs clear without waiting for a clock edge.
